// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns one load/store from EX/MEM into a
// valid/ready request plus response, stalls the pipeline meanwhile, and flags faults.
module mem_access_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MEM_ld,
  input  logic            MEM_str,
  input  logic [XLEN-1:0] MEM_alu_out,
  input  logic [XLEN-1:0] MEM_b2,
  output logic            stall,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_data_valid,
  output logic            fault,
  output logic [1:0]      fault_code
);

  // Handshake: a request transfers in a cycle where dmem_req_valid & dmem_req_ready;
  // until then valid, we, addr and wdata hold steady. dmem_rsp_valid is a one-cycle
  // pulse honoured only in WAIT_RSP and qualifies dmem_rsp_rdata.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_DONE     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam logic [1:0]  CODE_MISALIGN = 2'b01;
  localparam logic [1:0]  CODE_TIMEOUT  = 2'b10;
  localparam logic [1:0]  CODE_BOTH     = 2'b11;
  localparam logic [16:0] TIMEOUT_L     = 17'(TIMEOUT);

  // Exposed state for checkers and debug.
  state_t      state;
  logic [15:0] cnt;
  logic        access;
  logic        misaligned;
  logic        timeout_hit;
  logic [16:0] cnt_next;
  logic [15:0] cnt_sat;

  assign access     = MEM_ld | MEM_str;
  assign misaligned = |MEM_alu_out[1:0];

  // The counter "reaches" TIMEOUT at the edge ending the TIMEOUT-th busy cycle.
  assign cnt_next    = {1'b0, cnt} + 17'd1;
  assign cnt_sat     = (cnt == 16'hFFFF) ? cnt : cnt_next[15:0];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TIMEOUT_L);

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE:  stall = access;
        S_DONE:  stall = 1'b0;
        default: stall = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      ld_data        <= '0;
      ld_data_valid  <= 1'b0;
      fault          <= 1'b0;
      fault_code     <= 2'b00;
    end else begin
      ld_data_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (MEM_ld && MEM_str) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= CODE_BOTH;
          end else if (access && misaligned) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= CODE_MISALIGN;
          end else if (access) begin
            state          <= S_REQ;
            cnt            <= '0;
            dmem_req_valid <= 1'b1;
            dmem_req_we    <= MEM_str;
            dmem_req_addr  <= MEM_alu_out;
            dmem_req_wdata <= MEM_str ? MEM_b2 : '0;
          end
        end
        S_REQ: begin
          cnt <= cnt_sat;
          // Acceptance is not completion, so a timeout on this edge still faults.
          if (timeout_hit) begin
            state          <= S_FAULT;
            dmem_req_valid <= 1'b0;
            fault          <= 1'b1;
            fault_code     <= CODE_TIMEOUT;
          end else if (dmem_req_ready) begin
            state          <= S_WAIT_RSP;
            dmem_req_valid <= 1'b0;
          end
        end
        S_WAIT_RSP: begin
          cnt <= cnt_sat;
          if (dmem_rsp_valid) begin
            state         <= S_DONE;
            ld_data_valid <= ~dmem_req_we;
            if (!dmem_req_we) ld_data <= dmem_rsp_rdata;
          end else if (timeout_hit) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= CODE_TIMEOUT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_FAULT: begin
          state          <= S_FAULT;
          dmem_req_valid <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: scripted memory responder, load-data scoreboard,
// fault and reset scenarios; built with TIMEOUT=8.
module tb_mem_access_ctrl;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            clk;
  logic            rst;
  logic            MEM_ld;
  logic            MEM_str;
  logic [XLEN-1:0] MEM_alu_out;
  logic [XLEN-1:0] MEM_b2;
  logic            stall;
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic            dmem_req_we;
  logic [XLEN-1:0] dmem_req_addr;
  logic [XLEN-1:0] dmem_req_wdata;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rsp_rdata;
  logic [XLEN-1:0] ld_data;
  logic            ld_data_valid;
  logic            fault;
  logic [1:0]      fault_code;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_ld;
  logic [XLEN-1:0] mon_exp;

  mem_access_ctrl #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .MEM_ld(MEM_ld), .MEM_str(MEM_str),
    .MEM_alu_out(MEM_alu_out), .MEM_b2(MEM_b2),
    .stall(stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .ld_data(ld_data), .ld_data_valid(ld_data_valid),
    .fault(fault), .fault_code(fault_code)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ld_data_valid pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (!rst && ld_data_valid) begin
      if (exp_q.size() == 0) begin
        check("ld_unexpected", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ld_data", ld_data, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_req_valid"}, dmem_req_valid, 0);
    check({tag, "_req_we"}, dmem_req_we, 0);
    check({tag, "_req_addr"}, dmem_req_addr, 0);
    check({tag, "_req_wdata"}, dmem_req_wdata, 0);
    check({tag, "_ld_data"}, ld_data, 0);
    check({tag, "_ld_valid"}, ld_data_valid, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_fault_code"}, fault_code, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check_all_zero(tag);
    exp_q.delete();
    last_ld = '0;
    MEM_ld = 1'b0;
    MEM_str = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    step();
  endtask

  // Driver: presents one MEM-stage access and plays the memory with the given
  // ready/response delays, checking request stability and the stall count.
  task automatic do_access(input bit ld, input bit st, input logic [XLEN-1:0] addr,
                           input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] rdata,
                           input int ready_dly, input int rsp_dly, input string tag);
    int  req_cycles;
    int  wait_cycles;
    int  stall_cycles;
    bit  waiting;
    bit  done;
    MEM_ld = ld;
    MEM_str = st;
    MEM_alu_out = addr;
    MEM_b2 = wdata;
    if (ld) exp_q.push_back(rdata);
    req_cycles = 0;
    wait_cycles = 0;
    stall_cycles = 0;
    waiting = 0;
    done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dmem_req_ready = dmem_req_valid && (req_cycles >= ready_dly);
      if (dmem_req_valid) req_cycles++;
      dmem_rsp_valid = waiting && (wait_cycles == rsp_dly);
      dmem_rsp_rdata = dmem_rsp_valid ? rdata : XLEN'($urandom);
      if (waiting) wait_cycles++;
      @(negedge clk);
      if (dmem_req_valid) begin
        check({tag, "_req_addr"}, dmem_req_addr, addr);
        check({tag, "_req_we"}, dmem_req_we, st);
        check({tag, "_req_wdata"}, dmem_req_wdata, st ? wdata : '0);
        if (dmem_req_ready) waiting = 1;
      end
      if (stall) begin
        stall_cycles++;
      end else begin
        done = 1;
        check({tag, "_done_ld_valid"}, ld_data_valid, ld);
        check({tag, "_fault"}, fault, 0);
        if (st) check({tag, "_ld_data_kept"}, ld_data, last_ld);
      end
      step();
    end
    if (!done) check({tag, "_completed"}, 0, 1);
    check({tag, "_stall_cycles"}, stall_cycles, 3 + ready_dly + rsp_dly);
    check({tag, "_req_cycles"}, req_cycles, ready_dly + 1);
    if (ld) last_ld = rdata;
    MEM_ld = 1'b0;
    MEM_str = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic expect_fault(input logic [1:0] code, input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_req_valid"}, dmem_req_valid, 0);
      check({tag, "_stall"}, stall, 1);
      check({tag, "_fault"}, fault, 1);
      check({tag, "_code"}, fault_code, code);
      step();
    end
  endtask

  initial begin
    int req_seen;
    bit faulted;
    bit r_ld;
    rst = 1'b0;
    MEM_ld = 1'b0;
    MEM_str = 1'b0;
    MEM_alu_out = '0;
    MEM_b2 = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    last_ld = '0;
    #3;
    do_reset("reset");

    // Idle pipeline: no stall, no memory activity.
    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_req_valid", dmem_req_valid, 0);
    step();

    do_access(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, "t1_load");
    @(negedge clk);
    check("t1_after_stall", stall, 0);
    check("t1_after_ld_valid", ld_data_valid, 0);
    step();

    do_access(0, 1, 32'h204, 32'h12345678, 32'h0, 3, 2, "t2_store");

    // Back-to-back load then store: one non-stall DONE cycle between them.
    do_access(1, 0, 32'h300, 32'h0, 32'hA5A5_0F0F, 0, 0, "t5_load");
    do_access(0, 1, 32'h304, 32'hCAFE_F00D, 32'h0, 0, 0, "t5_store");
    @(negedge clk);
    check("t5_idle_stall", stall, 0);
    step();

    // Completion on the very edge the counter reaches TIMEOUT wins.
    do_access(1, 0, 32'h500, 32'h0, 32'h1357_9BDF, 0, TO - 2, "t4_edge");

    for (int i = 0; i < 6; i++) begin
      r_ld = 1'($urandom_range(0, 1));
      do_access(r_ld, !r_ld, {XLEN'($urandom_range(0, 16'hFFFF)), 2'b00} & 32'h3FFFC,
                XLEN'($urandom), XLEN'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    // Timeout: ready never rises.
    MEM_ld = 1'b1;
    MEM_alu_out = 32'h400;
    req_seen = 0;
    faulted = 0;
    for (int cyc = 0; cyc < 40 && !faulted; cyc++) begin
      @(negedge clk);
      if (dmem_req_valid) req_seen++;
      if (fault) faulted = 1;
      step();
    end
    check("t4_faulted", faulted, 1);
    check("t4_req_cycles", req_seen, TO);
    expect_fault(2'b10, "t4_fault");
    do_reset("t4_reset");

    // Misaligned load: no request, sticky fault.
    MEM_ld = 1'b1;
    MEM_alu_out = 32'h102;
    @(negedge clk);
    check("t3_idle_stall", stall, 1);
    check("t3_idle_req_valid", dmem_req_valid, 0);
    step();
    expect_fault(2'b01, "t3_fault");
    do_reset("t3_reset");

    MEM_ld = 1'b1;
    MEM_str = 1'b1;
    MEM_alu_out = 32'h200;
    step();
    expect_fault(2'b11, "both_fault");
    do_reset("both_reset");

    // Reset in WAIT_RSP abandons the access immediately.
    MEM_ld = 1'b1;
    MEM_alu_out = 32'h600;
    step();
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    check("t6_in_wait_stall", stall, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    @(posedge clk);
    #3;
    rst = 1'b0;
    MEM_ld = 1'b0;
    step();
    do_access(1, 0, 32'h700, 32'h0, 32'h0BAD_F00D, 1, 1, "t6_after");

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
